// File: rtl/ddram_pixel_writer.sv
// rtl/ddram_pixel_writer.sv - write-combining DDRAM write stage
// Merges half-qword pixel writes into full qwords and queues them toward DDRAM.
module ddram_pixel_writer #(
  parameter int FIFO_DEPTH   = 16,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic                         CLK_VIDEO,
  input  logic                         reset,
  input  logic                         in_we,
  input  logic [28:0]                  in_addr,
  input  logic [7:0]                   in_be,
  input  logic [63:0]                  in_din,
  input  logic                         flush,
  output logic                         DDRAM_CLK,
  input  logic                         DDRAM_BUSY,
  output logic [7:0]                   DDRAM_BURSTCNT,
  output logic [28:0]                  DDRAM_ADDR,
  output logic [63:0]                  DDRAM_DIN,
  output logic [7:0]                   DDRAM_BE,
  output logic                         DDRAM_WE,
  output logic                         DDRAM_RD,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow,
  output logic                         idle
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [28:0] addr;
    logic [7:0]  be;
    logic [63:0] data;
  } qword_t;

  logic          pend_valid_q, pend_valid_d;
  qword_t        pend_q, pend_d;
  logic          flush_req_q, flush_req_d;
  logic [7:0]    idle_cnt_q, idle_cnt_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  qword_t        out_q, out_d;
  logic          out_we_q, out_we_d;
  logic          overflow_q, overflow_d;
  qword_t        mem_q [FIFO_DEPTH];

  logic          acc;
  qword_t        in_qw;
  qword_t        merged;
  logic          push;
  qword_t        push_qw;
  logic          flush_now;
  logic [8:0]    idle_inc;
  logic [AW:0]   level;
  logic          fifo_empty;
  logic          fifo_full;
  logic          out_ld;
  logic          pop;
  logic          push_ok;

  // Pending-register resolution; at most one push per cycle, in priority order.
  always_comb begin
    acc          = in_we & (|in_be);
    in_qw.addr   = in_addr;
    in_qw.be     = in_be;
    in_qw.data   = in_din;
    merged       = pend_q;
    merged.be    = pend_q.be | in_be;
    for (int b = 0; b < 8; b++) begin
      if (in_be[b]) merged.data[8*b +: 8] = in_din[8*b +: 8];
    end
    push         = 1'b0;
    push_qw      = pend_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;

    if (acc) begin
      if (pend_valid_q && (in_addr != pend_q.addr)) begin
        push    = 1'b1;
        push_qw = pend_q;
        pend_d  = in_qw;
      end else if (pend_valid_q) begin
        pend_d = merged;
      end else begin
        pend_valid_d = 1'b1;
        pend_d       = in_qw;
      end
    end

    if (!push && pend_valid_d && (pend_d.be == 8'hFF)) begin
      push         = 1'b1;
      push_qw      = pend_d;
      pend_valid_d = 1'b0;
    end

    // A flush that coincides with a write is held over to act on the result.
    flush_now   = flush_req_q | (flush & ~acc);
    flush_req_d = flush_req_q | flush;
    if (flush_now && !push) begin
      if (pend_valid_d) begin
        push         = 1'b1;
        push_qw      = pend_d;
        pend_valid_d = 1'b0;
      end
      flush_req_d = flush & acc;
    end

    idle_inc   = {1'b0, idle_cnt_q} + 9'd1;
    idle_cnt_d = '0;
    if (!acc && pend_valid_d) begin
      if (idle_inc >= 9'(FLUSH_CYCLES)) begin
        if (!push) begin
          push         = 1'b1;
          push_qw      = pend_d;
          pend_valid_d = 1'b0;
        end else begin
          idle_cnt_d = 8'(FLUSH_CYCLES);
        end
      end else begin
        idle_cnt_d = idle_inc[7:0];
      end
    end
  end

  assign level      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == (AW+1)'(FIFO_DEPTH));

  always_comb begin
    out_ld     = ~out_we_q | ~DDRAM_BUSY;
    pop        = out_ld & ~fifo_empty;
    push_ok    = push & (~fifo_full | pop);
    overflow_d = overflow_q | (push & fifo_full & ~pop);
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    out_we_d   = out_we_q;
    out_d      = out_q;
    if (out_ld) begin
      out_we_d = ~fifo_empty;
      if (!fifo_empty) out_d = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      flush_req_q  <= 1'b0;
      idle_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_q        <= '0;
      out_we_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      flush_req_q  <= flush_req_d;
      idle_cnt_q   <= idle_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_q        <= out_d;
      out_we_q     <= out_we_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_qw;
  end

  assign DDRAM_CLK      = CLK_VIDEO;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_RD       = 1'b0;
  assign DDRAM_ADDR     = out_q.addr;
  assign DDRAM_DIN      = out_q.data;
  assign DDRAM_BE       = out_q.be;
  assign DDRAM_WE       = out_we_q;
  assign fifo_level     = level;
  assign overflow       = overflow_q;
  assign idle           = ~pend_valid_q & fifo_empty & ~out_we_q;

endmodule

// File: tb/tb_ddram_pixel_writer.sv
// tb/tb_ddram_pixel_writer.sv - self-checking bench for ddram_pixel_writer
// Queue-based reference model compared every cycle, plus directed literal checks.
module tb_ddram_pixel_writer;

  localparam int DEPTH = 16;
  localparam int FLUSH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_we = 1'b0;
  logic [28:0] in_addr = '0;
  logic [7:0]  in_be = '0;
  logic [63:0] in_din = '0;
  logic        flush = 1'b0;
  logic        busy = 1'b0;

  logic        ddram_clk;
  logic [7:0]  ddram_burstcnt;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic        ddram_we;
  logic        ddram_rd;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        idle;

  ddram_pixel_writer #(.FIFO_DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH)) dut (
    .CLK_VIDEO(clk), .reset(reset), .in_we(in_we), .in_addr(in_addr), .in_be(in_be),
    .in_din(in_din), .flush(flush), .DDRAM_CLK(ddram_clk), .DDRAM_BUSY(busy),
    .DDRAM_BURSTCNT(ddram_burstcnt), .DDRAM_ADDR(ddram_addr), .DDRAM_DIN(ddram_din),
    .DDRAM_BE(ddram_be), .DDRAM_WE(ddram_we), .DDRAM_RD(ddram_rd),
    .fifo_level(fifo_level), .overflow(overflow), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [28:0] a;
    logic [7:0]  be;
    logic [63:0] d;
    int          c;
  } wr_t;

  wr_t  mq[$];
  wr_t  wlog[$];
  wr_t  m_p;
  wr_t  m_out;
  bit   m_pv, m_we, m_ovf, m_freq;
  int   m_idle;
  bit   chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] merge_bytes(input logic [63:0] old, input logic [63:0] din,
                                              input logic [7:0] be);
    logic [63:0] mask = '0;
    for (int b = 0; b < 8; b++) if (be[b]) mask = mask | (64'hFF << (8*b));
    return (old & ~mask) | (din & mask);
  endfunction

  // Compare the DUT against the model, then advance the model by the upcoming edge.
  always @(negedge clk) begin : model
    bit  acc, have_push, eligible;
    wr_t pq, nw;
    if (chk_en) begin
      chk("ddram_we",   64'(ddram_we),   64'(m_we));
      chk("ddram_addr", 64'(ddram_addr), 64'(m_out.a));
      chk("ddram_be",   64'(ddram_be),   64'(m_out.be));
      chk("ddram_din",  ddram_din,       m_out.d);
      chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
      chk("overflow",   64'(overflow),   64'(m_ovf));
      chk("idle",       64'(idle),       64'(!m_pv && mq.size() == 0 && !m_we));
      chk("burstcnt",   64'(ddram_burstcnt), 64'd1);
      chk("ddram_rd",   64'(ddram_rd),   64'd0);
      chk("ddram_clk",  64'(ddram_clk),  64'(clk));
      if (ddram_we === 1'b1 && busy === 1'b0)
        wlog.push_back('{a: ddram_addr, be: ddram_be, d: ddram_din, c: cyc});
    end
    if (reset) begin
      mq.delete();
      m_pv = 0; m_we = 0; m_ovf = 0; m_freq = 0; m_idle = 0;
      m_p = '{a: '0, be: '0, d: '0, c: 0};
      m_out = '{a: '0, be: '0, d: '0, c: 0};
      chk_en = 1'b1;
    end else begin
      acc = in_we && (in_be != 8'h00);
      have_push = 0;
      pq = m_p;
      nw = '{a: in_addr, be: in_be, d: in_din, c: 0};
      // The output register only sees what was queued before this edge.
      if (!m_we || !busy) begin
        if (mq.size() != 0) begin
          m_out = mq.pop_front();
          m_we = 1;
        end else begin
          m_we = 0;
        end
      end
      if (acc) begin
        if (!m_pv) begin
          m_p = nw; m_pv = 1;
        end else if (m_p.a == in_addr) begin
          m_p.d = merge_bytes(m_p.d, in_din, in_be);
          m_p.be = m_p.be | in_be;
        end else begin
          pq = m_p; have_push = 1; m_p = nw;
        end
      end
      if (!have_push && m_pv && m_p.be == 8'hFF) begin
        pq = m_p; have_push = 1; m_pv = 0;
      end
      eligible = m_freq || (flush && !acc);
      if (eligible && !have_push) begin
        if (m_pv) begin pq = m_p; have_push = 1; m_pv = 0; end
        m_freq = flush && acc;
      end else begin
        m_freq = m_freq || flush;
      end
      if (acc) begin
        m_idle = 0;
      end else if (m_pv) begin
        m_idle = m_idle + 1;
        if (m_idle >= FLUSH && !have_push) begin
          pq = m_p; have_push = 1; m_pv = 0; m_idle = 0;
        end else if (m_idle > FLUSH) begin
          m_idle = FLUSH;
        end
      end else begin
        m_idle = 0;
      end
      if (have_push) begin
        if (mq.size() < DEPTH) mq.push_back(pq);
        else m_ovf = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic we, input logic [28:0] a, input logic [7:0] be,
                     input logic [63:0] d, input logic fl);
    in_we = we; in_addr = a; in_be = be; in_din = d; flush = fl;
    last_cyc = cyc;
    tick();
    in_we = 1'b0; flush = 1'b0;
  endtask

  task automatic idle_n(input int n);
    repeat (n) tick();
  endtask

  int n0, m0, base;
  logic [7:0] rbe;

  initial begin
    reset = 1'b1;
    idle_n(3);
    reset = 1'b0;
    chk("rst_we",    64'(ddram_we),   64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf",   64'(overflow),   64'd0);
    chk("rst_idle",  64'(idle),       64'd1);
    chk("rst_addr",  64'(ddram_addr), 64'd0);
    idle_n(2);

    // Merge two halves into one full qword
    wlog.delete();
    drv(1, 29'h100, 8'h0F, 64'h00000000_11223344, 0);
    drv(1, 29'h100, 8'hF0, 64'hAABBCCDD_00000000, 0);
    n0 = last_cyc;
    idle_n(6);
    chk("merge_count", 64'(wlog.size()), 64'd1);
    if (wlog.size() >= 1) begin
      chk("merge_addr", 64'(wlog[0].a), 64'h100);
      chk("merge_be",   64'(wlog[0].be), 64'hFF);
      chk("merge_din",  wlog[0].d, 64'hAABBCCDD_11223344);
      chk("merge_lat",  64'(wlog[0].c - n0), 64'd2);
    end
    chk("merge_idle", 64'(idle), 64'd1);

    // Descending addresses, second qword released by the idle timeout
    wlog.delete();
    drv(1, 29'h200, 8'hF0, {$urandom, $urandom}, 0);
    drv(1, 29'h1FF, 8'h0F, {$urandom, $urandom}, 0);
    n0 = last_cyc;
    idle_n(FLUSH + 16);
    chk("desc_t_count", 64'(wlog.size()), 64'd2);
    if (wlog.size() >= 2) begin
      chk("desc_t_a0",  64'(wlog[0].a), 64'h200);
      chk("desc_t_be0", 64'(wlog[0].be), 64'hF0);
      chk("desc_t_a1",  64'(wlog[1].a), 64'h1FF);
      chk("desc_t_be1", 64'(wlog[1].be), 64'h0F);
      chk("desc_t_lat0", 64'(wlog[0].c - n0), 64'd2);
      chk("desc_t_lat1", 64'(wlog[1].c - n0), 64'(FLUSH + 2));
    end

    // Descending addresses, second qword released by a flush pulse
    wlog.delete();
    drv(1, 29'h200, 8'hF0, {$urandom, $urandom}, 0);
    drv(1, 29'h1FF, 8'h0F, {$urandom, $urandom}, 0);
    drv(0, 29'h0, 8'h00, 64'h0, 1);
    m0 = last_cyc;
    idle_n(6);
    chk("desc_f_count", 64'(wlog.size()), 64'd2);
    if (wlog.size() >= 2) begin
      chk("desc_f_a1",  64'(wlog[1].a), 64'h1FF);
      chk("desc_f_lat", 64'(wlog[1].c - m0), 64'd2);
    end

    // Backpressure: 10 full qwords behind a busy bus
    wlog.delete();
    busy = 1'b1;
    for (int i = 0; i < 10; i++) drv(1, 29'(32'h300 + i), 8'hFF, {$urandom, $urandom}, 0);
    idle_n(90);
    chk("bp_level", 64'(fifo_level), 64'd9);
    chk("bp_we",    64'(ddram_we),   64'd1);
    chk("bp_addr",  64'(ddram_addr), 64'h300);
    busy = 1'b0;
    idle_n(15);
    chk("bp_count", 64'(wlog.size()), 64'd10);
    for (int i = 0; i < wlog.size(); i++) begin
      chk("bp_order", 64'(wlog[i].a), 64'(32'h300 + i));
      chk("bp_consec", 64'(wlog[i].c - wlog[0].c), 64'(i));
    end
    chk("bp_ovf", 64'(overflow), 64'd0);

    // Overflow: 20 qwords into 16 entries + output register
    wlog.delete();
    busy = 1'b1;
    for (int i = 0; i < 20; i++) drv(1, 29'(32'h400 + i), 8'hFF, {$urandom, $urandom}, 0);
    idle_n(5);
    chk("ovf_flag",  64'(overflow),   64'd1);
    chk("ovf_level", 64'(fifo_level), 64'(DEPTH));
    busy = 1'b0;
    idle_n(30);
    chk("ovf_count", 64'(wlog.size()), 64'(DEPTH + 1));
    for (int i = 0; i < wlog.size(); i++) chk("ovf_order", 64'(wlog[i].a), 64'(32'h400 + i));

    // Flush colliding with a write to a new address
    wlog.delete();
    drv(1, 29'h500, 8'h0F, {$urandom, $urandom}, 0);
    drv(1, 29'h600, 8'h0F, {$urandom, $urandom}, 1);
    idle_n(6);
    chk("fc_count", 64'(wlog.size()), 64'd2);
    if (wlog.size() >= 2) begin
      chk("fc_a0", 64'(wlog[0].a), 64'h500);
      chk("fc_a1", 64'(wlog[1].a), 64'h600);
      chk("fc_consec", 64'(wlog[1].c - wlog[0].c), 64'd1);
    end

    // Reset with data queued behind a busy bus
    busy = 1'b1;
    for (int i = 0; i < 5; i++) drv(1, 29'(32'h700 + i), 8'hFF, {$urandom, $urandom}, 0);
    idle_n(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_we",    64'(ddram_we),   64'd0);
    chk("rm_level", 64'(fifo_level), 64'd0);
    chk("rm_ovf",   64'(overflow),   64'd0);
    wlog.delete();
    busy = 1'b0;
    idle_n(20);
    chk("rm_nowrites", 64'(wlog.size()), 64'd0);

    // Randomized traffic against the model
    base = 32'h1000;
    for (int i = 0; i < 1500; i++) begin
      busy = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 15) == 0) base = base + 1;
      case ($urandom_range(0, 5))
        0: rbe = 8'h0F;
        1: rbe = 8'hF0;
        2: rbe = 8'hFF;
        3: rbe = 8'h00;
        4: rbe = 8'($urandom);
        default: rbe = 8'h0F;
      endcase
      if (i % 300 == 299) begin
        busy = 1'b0;
        idle_n(FLUSH + 8);
      end else begin
        drv(($urandom_range(0, 9) < 6), 29'(base + $urandom_range(0, 2)), rbe,
            {$urandom, $urandom}, ($urandom_range(0, 39) == 0));
      end
    end

    busy = 1'b0;
    drv(0, 29'h0, 8'h00, 64'h0, 1);
    begin
      int k = 0;
      while (idle !== 1'b1 && k < 200) begin
        tick();
        k++;
      end
      chk("final_idle", 64'(idle), 64'd1);
    end

    idle_n(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
